// File: rtl/ps_fragment_packer.sv
// ps_fragment_packer: splits a PacketStream into {fin,len-1} headed, ALIGN-padded fragments.
// Optional idle flush of partial fragments: define PS_FRAGMENT_PACKER_TIMEOUT_EN.
module ps_fragment_packer #(
  parameter int WIDTH   = 8,
  parameter int ALIGN   = 2,
  parameter int MAXLEN  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_val,
  input  logic             i_eop,
  output logic             i_rdy,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_val,
  input  logic             o_rdy
);
  localparam int CW = $clog2(MAXLEN + 1);
  localparam int AW = MAXLEN > 1 ? $clog2(MAXLEN) : 1;
  localparam int PW = $clog2(ALIGN + 1);
  if (MAXLEN < 1 || MAXLEN > 2 ** (WIDTH - 1) || ALIGN < 1 || TIMEOUT < 1) begin : g_bad_param
    $error("ps_fragment_packer: illegal parameter combination");
  end
  typedef enum logic [1:0] {st_collect, st_header, st_data, st_pad} state_t;
  state_t           r_state;
  logic [WIDTH-1:0] r_buf [2**AW];
  logic [CW-1:0]    r_wr_cnt;
  logic [CW-1:0]    r_rd_cnt;
  logic [PW-1:0]    r_pad_cnt;
  logic             r_fin;
  logic             w_acc;
  logic             w_full;
  logic             w_last;
  logic             w_tmo;
  logic [PW-1:0]    w_pad;
  assign i_rdy  = r_state == st_collect;
  assign o_val  = r_state != st_collect;
  assign w_acc  = i_val & i_rdy;
  assign w_full = r_wr_cnt == CW'(MAXLEN - 1);
  assign w_last = r_rd_cnt == r_wr_cnt - 1'b1;
  assign w_pad  = PW'((ALIGN - (int'(r_wr_cnt) + 1) % ALIGN) % ALIGN);
  assign o_dat  = r_state == st_header ? {r_fin, (WIDTH-1)'(r_wr_cnt - 1'b1)} :
                  r_state == st_data   ? r_buf[r_rd_cnt[AW-1:0]] : '0;
`ifdef PS_FRAGMENT_PACKER_TIMEOUT_EN
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] r_idle;
  assign w_tmo = r_state == st_collect && !w_acc && r_wr_cnt != '0 && r_idle == TW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      r_idle <= '0;
    else
      r_idle <= (r_state != st_collect || w_acc || w_tmo || r_wr_cnt == '0) ? '0 : r_idle + 1'b1;
`else
  assign w_tmo = 1'b0;
`endif
  // Buffer contents need no reset: every emitted word was written in the same fragment.
  always_ff @(posedge clk)
    if (w_acc) r_buf[r_wr_cnt[AW-1:0]] <= i_dat;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= st_collect;
      r_wr_cnt  <= '0;
      r_rd_cnt  <= '0;
      r_pad_cnt <= '0;
      r_fin     <= 1'b0;
    end else begin
      case (r_state)
        st_collect:
          if (w_acc) begin
            r_wr_cnt <= r_wr_cnt + 1'b1;
            if (i_eop || w_full) begin
              r_fin   <= i_eop;
              r_state <= st_header;
            end
          end else if (w_tmo) begin
            r_fin   <= 1'b0;
            r_state <= st_header;
          end
        st_header: begin
          r_pad_cnt <= w_pad;
          r_rd_cnt  <= '0;
          if (o_rdy) r_state <= st_data;
        end
        st_data:
          if (o_rdy) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
            if (w_last) begin
              r_wr_cnt <= r_pad_cnt != '0 ? r_wr_cnt : '0;
              r_state  <= r_pad_cnt != '0 ? st_pad : st_collect;
            end
          end
        st_pad:
          if (o_rdy) begin
            r_pad_cnt <= r_pad_cnt - 1'b1;
            if (r_pad_cnt == PW'(1)) begin
              r_wr_cnt <= '0;
              r_state  <= st_collect;
            end
          end
      endcase
    end
  end
endmodule

// File: tb/tb_ps_fragment_packer.sv
// tb_ps_fragment_packer: random packets and output stalls checked against a fragment-list model.
module tb_ps_fragment_packer;
  localparam int WIDTH = 8, ALIGN = 2, MAXLEN = 4, TIMEOUT = 8;
  logic clk = 0, reset_n = 0;
  logic [7:0] i_dat = 0, o_dat;
  logic i_val = 0, i_eop = 0, i_rdy, o_val, o_rdy = 1;
  int n_cmp = 0, n_err = 0, pops = 0, rdy_mode = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pkt[$];
  logic stalled = 0;
  logic [7:0] held = 0;

  ps_fragment_packer #(.WIDTH(WIDTH), .ALIGN(ALIGN), .MAXLEN(MAXLEN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .i_dat(i_dat), .i_val(i_val), .i_eop(i_eop), .i_rdy(i_rdy),
    .o_dat(o_dat), .o_val(o_val), .o_rdy(o_rdy));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected output of one whole packet: MAXLEN-sized chunks, header, data, zero pad.
  task automatic model_pkt();
    for (int s = 0; s < pkt.size(); s += MAXLEN) begin
      int n = (pkt.size() - s) < MAXLEN ? pkt.size() - s : MAXLEN;
      exp_q.push_back(8'(n - 1) | ((s + n == pkt.size()) ? 8'h80 : 8'h00));
      for (int i = 0; i < n; i++) exp_q.push_back(pkt[s + i]);
      repeat ((ALIGN - (1 + n) % ALIGN) % ALIGN) exp_q.push_back(8'h00);
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic eop, input bit gap);
    int n = 0;
    @(negedge clk);
    if (gap) repeat ($urandom_range(0, 2)) @(negedge clk);
    i_val = 1; i_dat = d; i_eop = eop;
    while (!i_rdy && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) check("in_wait", n, 0);
    @(posedge clk);
    #1 i_val = 0; i_eop = 0;
  endtask

  task automatic send_pkt(input bit gap);
    model_pkt();
    foreach (pkt[i]) send_word(pkt[i], i == pkt.size() - 1, gap);
  endtask

  task automatic rand_pkt(input int len);
    pkt.delete();
    repeat (len) pkt.push_back(8'($urandom));
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_val) && n < 3000) begin @(negedge clk); n++; end
    check("drain", exp_q.size() + (n >= 3000 ? 1000 : 0), 0);
  endtask

  initial forever begin
    @(negedge clk);
    o_rdy = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? ($urandom_range(0, 3) != 0) : 1'b0;
    if (!reset_n) stalled = 0;
    else begin
      if (stalled) begin
        check("hold_val", o_val, 1);
        check("hold_dat", o_dat, held);
      end
      if (o_val) check("rdy_low", i_rdy, 0);
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) check("extra_word", o_dat, 32'hdead);
        else check("out_word", o_dat, exp_q.pop_front());
        pops++;
      end
      stalled = o_val && !o_rdy;
      held = o_dat;
    end
  end

  initial begin
    int base, n;
    repeat (3) @(negedge clk);
    check("rst_oval", o_val, 0);
    check("rst_irdy", i_rdy, 1);
    reset_n = 1;
    pkt = '{8'hA1, 8'hB2, 8'hC3};
    send_pkt(0); drain();
    pkt = '{8'h11, 8'h22};
    send_pkt(0); drain();
    pkt = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35};
    send_pkt(0); drain();
    rdy_mode = 1;
    send_pkt(1); drain();
    for (int k = 0; k < 25; k++) begin
      rand_pkt($urandom_range(1, 10));
      send_pkt(1);
    end
    drain();
    rdy_mode = 0;
    // Reset while the first data word is on the output.
    base = pops; n = 0;
    pkt = '{8'h51, 8'h52, 8'h53};
    send_pkt(0);
    while (pops < base + 1 && n < 500) begin @(posedge clk); n++; end
    check("reach_data", n < 500, 1);
    #2 reset_n = 0;
    #1 check("rst_mid_oval", o_val, 0);
    check("rst_mid_irdy", i_rdy, 1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1;
    repeat (6) @(negedge clk);
    check("idle_after_rst", o_val, 0);
    pkt = '{8'h5A};
    send_pkt(0); drain();
`ifdef PS_FRAGMENT_PACKER_TIMEOUT_EN
    exp_q.push_back(8'h01); exp_q.push_back(8'h61); exp_q.push_back(8'h62); exp_q.push_back(8'h00);
    send_word(8'h61, 0, 0);
    send_word(8'h62, 0, 0);
    repeat (12) @(negedge clk);
    drain();
    exp_q.push_back(8'h80); exp_q.push_back(8'h63);
    send_word(8'h63, 1, 0);
    drain();
`else
    pkt = '{8'h61, 8'h62, 8'h63};
    model_pkt();
    send_word(8'h61, 0, 0);
    send_word(8'h62, 0, 0);
    repeat (20) @(negedge clk);
    check("partial_hold", o_val, 0);
    send_word(8'h63, 1, 0);
    drain();
`endif
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
